// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared types and defaults for the fetch stage.
//   - fetch_state_t : fetch controller state encoding
//   - if_id_t       : 65-bit IF/ID pipeline register {pc4, instr, valid}
//   - NOP_INSTR_DEF, RESET_PC_DEF : default parameter values
//   - pc_plus4()    : 32-bit PC increment, wraps modulo 2^32
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
//   Single-entry holding buffer for an instruction that arrived while the
//   pipeline was stalled.
//   Ports:
//     clk_i   : clock
//     rst_i   : asynchronous active-low reset
//     load_i  : capture data_i, buffer becomes full
//     drain_i : buffer contents consumed, buffer becomes empty
//     clear_i : discard contents (flush); wins over load and drain
//     data_i  : entry to capture
//     data_o  : held entry
//     full_o  : buffer holds an entry
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  logic   drain_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output if_id_t data_o,
    output logic   full_o
);

    if_id_t data_q;
    logic   full_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl
//   Instruction fetch stage: owns the PC, the instruction-memory request
//   handshake and the IF/ID register. Applies load-use stalls (hold) and
//   taken-branch flushes (NOP + redirect) decided by the hazard unit.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no request issued; waiting for start_i
//   FETCH   | request at pc_o while the skid buffer is empty
//   DISCARD | flushed while a request was outstanding; wait for it, drop
//           | the word, then redirect to the latched target
//
//   Ports:
//     clk_i, rst_i                : clock, asynchronous active-low reset
//     start_i                     : fetch enable
//     hd_sel_i                    : 1 = normal, 0 = load-use stall
//     hd_flush_i, branch_target_i : taken-branch flush and redirect address
//     imem_req_o, imem_addr_o     : fetch request / address
//     imem_ready_i, imem_data_i   : response handshake / instruction word
//     pc_o                        : current fetch PC
//     if_id_pc4_o, if_id_instr_o, if_id_valid_o : IF/ID register
//   Optional (FETCH_PERF_CNT_EN):
//     stall_cnt_o, flush_cnt_o    : saturating stall-cycle / flush counters
module fetch_stage_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hd_sel_i,
    input  logic        hd_flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
`ifdef FETCH_PERF_CNT_EN
    output logic        if_id_valid_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`else
    output logic        if_id_valid_o
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    if_id_t       if_id_q, if_id_d;

    logic         skid_load, skid_drain, skid_clear, skid_full;
    if_id_t       skid_data;
    if_id_t       fetched;
    if_id_t       bubble;
    logic         req, xfer, stall, flush_acc;

    assign req     = ((state_q == ST_FETCH) && !skid_full) || (state_q == ST_DISCARD);
    assign xfer    = req && imem_ready_i;
    assign stall   = !hd_sel_i;
    assign fetched = '{pc4: pc_plus4(pc_q), instr: imem_data_i, valid: 1'b1};
    assign bubble  = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .data_i  (fetched),
        .data_o  (skid_data),
        .full_o  (skid_full)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        if_id_d    = if_id_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        flush_acc  = 1'b0;

        // Datapath action; stall outranks flush.
        if (stall) begin
            if (xfer && (state_q == ST_FETCH))
                skid_load = 1'b1;
        end else if (hd_flush_i) begin
            flush_acc  = 1'b1;
            if_id_d    = bubble;
            skid_clear = 1'b1;
            if (!req || xfer) begin
                pc_d = branch_target_i;
            end else begin
                // Address must stay stable until the memory answers.
                target_d = branch_target_i;
                state_d  = ST_DISCARD;
            end
        end else if (state_q == ST_DISCARD) begin
            if_id_d = bubble;
        end else if (skid_full) begin
            if_id_d    = skid_data;
            pc_d       = pc_plus4(pc_q);
            skid_drain = 1'b1;
        end else if (xfer) begin
            if_id_d = fetched;
            pc_d    = pc_plus4(pc_q);
        end else begin
            if_id_d = bubble;
        end

        // Sequencing.
        case (state_q)
            ST_IDLE: begin
                if (start_i)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if ((state_d == ST_FETCH) && !start_i && !stall && (xfer || !req))
                    state_d = ST_IDLE;
            end
            ST_DISCARD: begin
                // The dropped word is never an instruction, so the redirect
                // proceeds even under a stall; a same-cycle flush target wins.
                if (xfer) begin
                    state_d = ST_FETCH;
                    if (!flush_acc)
                        pc_d = target_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            target_q <= 32'h0;
            if_id_q  <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            if_id_q  <= if_id_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_acc && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, hd_sel, hd_flush, ready;
    logic [31:0] target, data;
    logic        req, valid;
    logic [31:0] addr, pc, pc4, instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .hd_sel_i        (hd_sel),
        .hd_flush_i      (hd_flush),
        .branch_target_i (target),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ready_i    (ready),
        .imem_data_i     (data),
        .pc_o            (pc),
        .if_id_pc4_o     (pc4),
        .if_id_instr_o   (instr),
`ifdef FETCH_PERF_CNT_EN
        .if_id_valid_o   (valid),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`else
        .if_id_valid_o   (valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid);
        check({tag, ".pc4"},   pc4,   e_pc4);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, e_valid});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hd_sel = 1'b1; hd_flush = 1'b0;
        ready = 1'b0; target = 32'h0; data = 32'h0;

        // Reset held three cycles, released with start low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold.req", {31'h0, req}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.pc", pc, 32'h0);
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        check("reset.req", {31'h0, req}, 32'h0);

        // Streaming, zero-wait memory
        start = 1'b1; ready = 1'b1; data = 32'h11;
        @(negedge clk);
        check("fetch0.req", {31'h0, req}, 32'h1);
        check("fetch0.addr", addr, 32'h0);
        @(negedge clk);
        check("stream1.pc", pc, 32'h4);
        check_ifid("stream1", 32'h4, 32'h11, 1'b1);
        data = 32'h22;
        @(negedge clk);
        check("stream2.pc", pc, 32'h8);
        check_ifid("stream2", 32'h8, 32'h22, 1'b1);

        // Load-use stall at pc=8 with ready high: word goes to skid buffer
        data = 32'h33; hd_sel = 1'b0;
        @(negedge clk);
        check("stall.pc", pc, 32'h8);
        check_ifid("stall", 32'h8, 32'h22, 1'b1);
        check("stall.req", {31'h0, req}, 32'h0);
        hd_sel = 1'b1; data = 32'hBAD0;
        @(negedge clk);
        check("release.pc", pc, 32'hC);
        check_ifid("release", 32'hC, 32'h33, 1'b1);
        check("release.req", {31'h0, req}, 32'h1);

        // Flush with zero-wait memory
        hd_flush = 1'b1; target = 32'h40; data = 32'h44;
        @(negedge clk);
        check_ifid("flush0", 32'h0, 32'h0, 1'b0);
        check("flush0.addr", addr, 32'h40);
        hd_flush = 1'b0; data = 32'h55;
        @(negedge clk);
        check("f40.pc", pc, 32'h44);
        check_ifid("f40", 32'h44, 32'h55, 1'b1);

        // Flush during a multi-cycle memory wait -> DISCARD
        ready = 1'b0;
        @(negedge clk);
        check("wait1.req", {31'h0, req}, 32'h1);
        check("wait1.addr", addr, 32'h44);
        check_ifid("wait1", 32'h0, 32'h0, 1'b0);
        hd_flush = 1'b1; target = 32'h40;
        @(negedge clk);
        check("disc.addr", addr, 32'h44);
        check("disc.req", {31'h0, req}, 32'h1);
        hd_flush = 1'b0; target = 32'h0;
        @(negedge clk);
        check("disc2.addr", addr, 32'h44);
        ready = 1'b1; data = 32'hDEAD_BEEF;
        @(negedge clk);
        check_ifid("disc_drop", 32'h0, 32'h0, 1'b0);
        check("redir.addr", addr, 32'h40);
        check("redir.req", {31'h0, req}, 32'h1);
        data = 32'h66;
        @(negedge clk);
        check_ifid("after_disc", 32'h44, 32'h66, 1'b1);

        // Stall and flush together: flush ignored
        hd_sel = 1'b0; hd_flush = 1'b1; target = 32'h200; ready = 1'b0;
        @(negedge clk);
        check("both.pc", pc, 32'h44);
        check_ifid("both", 32'h44, 32'h66, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("both.stall_cnt", stall_cnt, 32'd2);
        check("both.flush_cnt", flush_cnt, 32'd2);
`endif
        hd_sel = 1'b1;

        // PC wrap at the top of the address space
        target = 32'hFFFF_FFFC; ready = 1'b1; data = 32'h77;
        @(negedge clk);
        check("wrap0.pc", pc, 32'hFFFF_FFFC);
        hd_flush = 1'b0; data = 32'h88;
        @(negedge clk);
        check("wrap.pc", pc, 32'h0);
        check_ifid("wrap", 32'h0, 32'h88, 1'b1);

        // start low: last transfer completes, then IDLE and bubbles
        start = 1'b0; data = 32'h99;
        @(negedge clk);
        check("stop.pc", pc, 32'h4);
        check_ifid("stop", 32'h4, 32'h99, 1'b1);
        check("stop.req", {31'h0, req}, 32'h0);
        @(negedge clk);
        check("idle.valid", {31'h0, valid}, 32'h0);

        // Asynchronous reset aborts an outstanding request
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        check("pre_rst.req", {31'h0, req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.req", {31'h0, req}, 32'h0);
        check("async_rst.pc", pc, 32'h0);
        @(negedge clk);
        start = 1'b0; ready = 1'b1; data = 32'hAAAA;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_rdy.req", {31'h0, req}, 32'h0);
        check("late_rdy.pc", pc, 32'h0);
        check_ifid("late_rdy", 32'h0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
